conv_stream_sequencer: RTL and testbench

Front-end controller for the layer-1 convolution engine. Accepts a raw, unpadded pixel stream over a valid/ready handshake and emits the padded raster stream the engine consumes on in_valid/in_data:
- per image row: PADDING left zeros, IMG_W pixels, PADDING right zeros;
- after the last row: PADDING full zero rows to flush the line windows.

It then counts the engine's out_valid beats and signals frame completion. One instance sits between the pixel source and conv2d_layer1.

---
 rtl/conv_stream_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_conv_stream_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_sequencer.sv
// Pads a raw pixel stream into the conv engine raster and flags frame end; conv_in_* registered, 1-cycle latency.
// s_ready is high only in PIX (source stalls make bubbles); define TOP_PAD_EN for PADDING zero rows above the image.
module conv_stream_sequencer #(
   parameter int IMG_W   = 4,
   parameter int IMG_H   = 4,
   parameter int PADDING = 1,
   parameter int DATA_W  = 8,
   parameter int OUT_CNT = IMG_W * IMG_H
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              conv_in_valid,
   output logic [DATA_W-1:0] conv_in_data,
   input  logic              conv_out_valid,
   output logic              busy,
   output logic              done
);

   localparam int ROW_BEATS = IMG_W + 2 * PADDING;
   localparam int PAD_BEATS = PADDING * ROW_BEATS;
   localparam int COL_MAX   = (IMG_W > PADDING) ? IMG_W : PADDING;
   localparam int PAD_MAX   = (PAD_BEATS > 0) ? PAD_BEATS : 1;
   localparam int COL_W     = $clog2(COL_MAX + 1);
   localparam int ROW_W     = $clog2(IMG_H + 1);
   localparam int PAD_W     = $clog2(PAD_MAX + 1);
   localparam int OUT_W     = $clog2(OUT_CNT + 1);

   localparam logic [COL_W-1:0] LAST_PIX  = COL_W'(IMG_W - 1);
   localparam logic [COL_W-1:0] LAST_SIDE = COL_W'(PADDING - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
   localparam logic [PAD_W-1:0] LAST_PAD  = PAD_W'(PAD_BEATS - 1);
   localparam logic [OUT_W-1:0] OUT_TERM  = OUT_W'(OUT_CNT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TPAD  = 3'd1,
      LPAD  = 3'd2,
      PIX   = 3'd3,
      RPAD  = 3'd4,
      BPAD  = 3'd5,
      DRAIN = 3'd6
   } state_t;

   state_t            state, nxt_state;
   logic [COL_W-1:0]  col, nxt_col;
   logic [ROW_W-1:0]  row, nxt_row;
   logic [PAD_W-1:0]  pad_cnt, nxt_pad;
   logic [OUT_W-1:0]  out_cnt;
   logic              out_full;
   logic              beat_vld;
   logic [DATA_W-1:0] beat_dat;
   logic              frame_start;

   assign frame_start = (state == IDLE) && start;
   assign out_full    = (out_cnt == OUT_TERM);
   assign s_ready     = (state == PIX);
   assign done        = (state == DRAIN) && out_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         col     <= '0;
         row     <= '0;
         pad_cnt <= '0;
      end else begin
         state   <= nxt_state;
         col     <= nxt_col;
         row     <= nxt_row;
         pad_cnt <= nxt_pad;
      end
   end

   // One beat decision per cycle; pad states never stall, PIX waits on s_valid.
   always_comb begin
      nxt_state = state;
      nxt_col   = col;
      nxt_row   = row;
      nxt_pad   = pad_cnt;
      beat_vld  = 1'b0;
      beat_dat  = '0;
      case (state)
         IDLE: begin
            if (start) begin
               nxt_col = '0;
               nxt_row = '0;
               nxt_pad = '0;
`ifdef TOP_PAD_EN
               if (PADDING > 0) nxt_state = TPAD;
               else             nxt_state = PIX;
`else
               if (PADDING > 0) nxt_state = LPAD;
               else             nxt_state = PIX;
`endif
            end
         end
`ifdef TOP_PAD_EN
         TPAD: begin
            beat_vld = 1'b1;
            if (pad_cnt == LAST_PAD) begin
               nxt_pad   = '0;
               nxt_state = LPAD;
            end else begin
               nxt_pad = pad_cnt + 1'b1;
            end
         end
`endif
         LPAD: begin
            beat_vld = 1'b1;
            if (col == LAST_SIDE) begin
               nxt_col   = '0;
               nxt_state = PIX;
            end else begin
               nxt_col = col + 1'b1;
            end
         end
         PIX: begin
            if (s_valid) begin
               beat_vld = 1'b1;
               beat_dat = s_data;
               if (col == LAST_PIX) begin
                  nxt_col = '0;
                  // Without padding, rows run back to back straight out of PIX.
                  if (PADDING > 0)          nxt_state = RPAD;
                  else if (row == LAST_ROW) nxt_state = DRAIN;
                  else                      nxt_row   = row + 1'b1;
               end else begin
                  nxt_col = col + 1'b1;
               end
            end
         end
         RPAD: begin
            beat_vld = 1'b1;
            if (col == LAST_SIDE) begin
               nxt_col = '0;
               if (row == LAST_ROW) begin
                  nxt_state = BPAD;
               end else begin
                  nxt_row   = row + 1'b1;
                  nxt_state = LPAD;
               end
            end else begin
               nxt_col = col + 1'b1;
            end
         end
         BPAD: begin
            beat_vld = 1'b1;
            if (pad_cnt == LAST_PAD) begin
               nxt_pad   = '0;
               nxt_state = DRAIN;
            end else begin
               nxt_pad = pad_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (out_full) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_in_valid <= 1'b0;
         conv_in_data  <= '0;
         busy          <= 1'b0;
         out_cnt       <= '0;
      end else begin
         conv_in_valid <= beat_vld;
         if (beat_vld) conv_in_data <= beat_dat;

         if (frame_start) busy <= 1'b1;
         else if (done)   busy <= 1'b0;

         // Saturating at the terminal count keeps stray engine beats from re-arming done.
         if (frame_start)                              out_cnt <= '0;
         else if (busy && conv_out_valid && !out_full) out_cnt <= out_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// Randomized bench for conv_stream_sequencer: padded raster, bubbles, done timing, restart, reset, no-pad build.
module tb_conv_stream_sequencer;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int P  = 1;
   localparam int DW = 8;
   localparam int OC = W * H;
   localparam int RB = W + 2 * P;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          conv_in_valid;
   logic [DW-1:0] conv_in_data;
   logic          conv_out_valid = 1'b0;
   logic          busy;
   logic          done;

   logic          np_start = 1'b0;
   logic          np_s_valid = 1'b0;
   logic [DW-1:0] np_s_data = '0;
   logic          np_s_ready;
   logic          np_in_valid;
   logic [DW-1:0] np_in_data;
   logic          np_out_valid = 1'b0;
   logic          np_busy;
   logic          np_done;

   conv_stream_sequencer #(.IMG_W(W), .IMG_H(H), .PADDING(P), .DATA_W(DW), .OUT_CNT(OC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .conv_in_valid(conv_in_valid), .conv_in_data(conv_in_data),
      .conv_out_valid(conv_out_valid), .busy(busy), .done(done)
   );

   conv_stream_sequencer #(.IMG_W(W), .IMG_H(H), .PADDING(0), .DATA_W(DW), .OUT_CNT(OC)) dut_np (
      .clk(clk), .rst_n(rst_n), .start(np_start), .s_valid(np_s_valid), .s_data(np_s_data),
      .s_ready(np_s_ready), .conv_in_valid(np_in_valid), .conv_in_data(np_in_data),
      .conv_out_valid(np_out_valid), .busy(np_busy), .done(np_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   logic [DW-1:0] pix_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] np_q[$];
   bit   mon_en = 1'b0;
   int   first_cyc, last_cyc, rdy_cnt, stall_cnt, done_cnt, done_cyc, np_done_cnt;
   logic done_busy;

   always @(negedge clk) begin
      if (mon_en) begin
         if (conv_in_valid) begin
            if (got_q.size() == 0) first_cyc = cyc;
            got_q.push_back(conv_in_data);
            last_cyc = cyc;
         end
         if (s_ready) rdy_cnt++;
         if (s_ready && !s_valid) stall_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
         end
      end
      if (np_in_valid) np_q.push_back(np_in_data);
      if (np_done) np_done_cnt++;
   end

   // Reference raster: optional top rows, each row framed by side zeros, bottom flush rows.
   task automatic build_exp();
      exp_q.delete();
`ifdef TOP_PAD_EN
      repeat (P * RB) exp_q.push_back('0);
`endif
      for (int r = 0; r < H; r++) begin
         repeat (P) exp_q.push_back('0);
         for (int c = 0; c < W; c++) exp_q.push_back(pix_q[r * W + c]);
         repeat (P) exp_q.push_back('0);
      end
      repeat (P * RB) exp_q.push_back('0);
   endtask

   task automatic run_frame(input string name, input bit seq_pix, input int gap_pct,
                            input int stall_at, input int n_pulse, input int restart_at,
                            input int rst_at, input bit hold_idle, input int exp_bub,
                            input int exp_rdy);
      int idx, stall_left, k16, t0, wait_n, bub, exp_done;
      bit aborted, stalled, restarted;
      pix_q.delete();
      for (int i = 0; i < OC; i++) pix_q.push_back(seq_pix ? DW'(i + 1) : DW'($urandom));
      build_exp();
      got_q.delete();
      rdy_cnt = 0; stall_cnt = 0; done_cnt = 0;
      done_cyc = -1; last_cyc = -1; first_cyc = -1; k16 = -1;
      idx = 0; stall_left = 0; aborted = 0; stalled = 0; restarted = 0;

      if (hold_idle) begin
         @(posedge clk); #1;
         s_valid = 1'b1;
         s_data  = 8'hEE;
         repeat (2) @(negedge clk);
         check_eq({name, "/idle_s_ready"}, s_ready, 0);
         check_eq({name, "/idle_in_valid"}, conv_in_valid, 0);
      end

      mon_en = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;

      fork
         begin
            t0 = cyc;
            while (!aborted && idx < OC) begin
               if (cyc - t0 > 400) begin
                  check_eq({name, "/src_timeout"}, idx, OC);
                  break;
               end
               if (idx == rst_at) begin
                  s_valid = 1'b0;
                  rst_n   = 1'b0;
                  #1;
                  check_eq({name, "/rst_in_valid"}, conv_in_valid, 0);
                  check_eq({name, "/rst_in_data"}, conv_in_data, 0);
                  check_eq({name, "/rst_s_ready"}, s_ready, 0);
                  check_eq({name, "/rst_busy"}, busy, 0);
                  check_eq({name, "/rst_done"}, done, 0);
                  @(posedge clk); #1 rst_n = 1'b1;
                  aborted = 1;
                  break;
               end
               start = (idx == restart_at) && !restarted;
               if (start) restarted = 1;
               if (idx == stall_at && !stalled) begin
                  stall_left = 3;
                  stalled    = 1;
               end
               if (stall_left > 0) begin
                  s_valid = 1'b0;
                  stall_left--;
               end else begin
                  s_valid = ($urandom_range(99) >= gap_pct);
               end
               s_data = s_valid ? pix_q[idx] : DW'($urandom);
               @(negedge clk);
               if (s_valid && s_ready) idx++;
               @(posedge clk); #1;
            end
            s_valid = 1'b0;
            start   = 1'b0;
         end
         begin
            for (int k = 0; k < n_pulse; k++) begin
               repeat ($urandom_range(3)) begin
                  @(posedge clk); #1;
               end
               conv_out_valid = 1'b1;
               if (k == OC - 1) k16 = cyc;
               @(posedge clk); #1 conv_out_valid = 1'b0;
            end
         end
      join

      if (aborted) begin
         repeat (3) @(negedge clk);
         check_eq({name, "/post_rst_in_valid"}, conv_in_valid, 0);
         check_eq({name, "/post_rst_busy"}, busy, 0);
         check_eq({name, "/post_rst_s_ready"}, s_ready, 0);
         mon_en = 1'b0;
         return;
      end

      wait_n = 0;
      while (done_cnt == 0 && wait_n < 300) begin
         @(negedge clk);
         wait_n++;
      end
      @(posedge clk); #1 conv_out_valid = 1'b1;
      @(posedge clk); #1 conv_out_valid = 1'b0;
      repeat (4) @(negedge clk);
      mon_en = 1'b0;

      check_eq({name, "/beats"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_eq($sformatf("%s/beat%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
      bub = last_cyc - first_cyc + 1 - got_q.size();
      check_eq({name, "/bubbles"}, bub, (exp_bub >= 0) ? exp_bub : stall_cnt);
      if (exp_rdy >= 0) check_eq({name, "/s_ready_cycles"}, rdy_cnt, exp_rdy);
      check_eq({name, "/done_count"}, done_cnt, 1);
      exp_done = (last_cyc > k16 + 1) ? last_cyc : k16 + 1;
      check_eq({name, "/done_cycle"}, done_cyc, exp_done);
      check_eq({name, "/busy_at_done"}, done_busy, 1);
      check_eq({name, "/busy_after"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int np_idx, t0;
      #12;
      check_eq("reset/in_valid", conv_in_valid, 0);
      check_eq("reset/in_data", conv_in_data, 0);
      check_eq("reset/s_ready", s_ready, 0);
      check_eq("reset/busy", busy, 0);
      check_eq("reset/done", done, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_frame("t1_basic",   1, 0, -1, OC,     -1, -1, 0, 0, OC);
      run_frame("t2_stall",   1, 0,  5, OC,     -1, -1, 0, 3, OC + 3);
      run_frame("t3_sat",     0, 0, -1, OC + 4, -1, -1, 0, 0, OC);
      run_frame("t4_restart", 1, 0, -1, OC,      5, -1, 1, 0, OC);
      run_frame("t5_reset",   1, 0, -1, 0,      -1,  7, 0, 0, -1);
      run_frame("t5_after",   1, 0, -1, OC,     -1, -1, 0, 0, OC);
      for (int f = 0; f < 4; f++)
         run_frame($sformatf("rnd%0d", f), 0, 25, -1, OC + int'($urandom_range(3)), -1, -1, 0, -1, -1);

      np_q.delete();
      np_done_cnt = 0;
      np_idx = 0;
      @(posedge clk); #1;
      np_start = 1'b1; np_s_valid = 1'b1; np_s_data = 8'd1; np_out_valid = 1'b1;
      @(posedge clk); #1 np_start = 1'b0;
      t0 = cyc;
      while (np_idx < OC && cyc - t0 < 200) begin
         @(negedge clk);
         if (np_s_ready) np_idx++;
         @(posedge clk); #1 np_s_data = DW'(np_idx + 1);
      end
      np_s_valid = 1'b0;
      t0 = cyc;
      while (np_done_cnt == 0 && cyc - t0 < 100) @(negedge clk);
      repeat (5) @(negedge clk);
      np_out_valid = 1'b0;
      check_eq("nopad/beats", np_q.size(), OC);
      for (int i = 0; i < OC && i < np_q.size(); i++)
         check_eq($sformatf("nopad/beat%0d", i), 32'(np_q[i]), i + 1);
      check_eq("nopad/done_count", np_done_cnt, 1);
      check_eq("nopad/busy_after", np_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
